// File: rtl/video_fetch.sv
// rtl/video_fetch.sv - line fetcher: Wishbone byte reads from video RAM into a show-ahead FIFO
module video_fetch #(
    parameter int                       FIFO_DEPTH    = 4,
    parameter int                       WB_ADDR_WIDTH = 17,
    parameter int                       DATA_WIDTH    = 8,
    parameter logic [WB_ADDR_WIDTH-1:0] VRAM_BASE     = 17'h08000
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_i,
    input  logic                     line_start_i,
    input  logic [10:0]              line_addr_i,
    input  logic [6:0]               line_len_i,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    output logic                     wb_we_o,
    output logic                     wb_cycle_o,
    output logic                     wb_strobe_o,
    input  logic                     wb_stall_i,
    input  logic                     wb_ack_i,
    input  logic [DATA_WIDTH-1:0]    wb_data_i,
    input  logic                     rd_en_i,
    output logic [DATA_WIDTH-1:0]    rd_data_o,
    output logic                     empty_o,
    output logic                     busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2,
        ABORT    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [10:0]           offset;
    logic [6:0]            remaining;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;

    logic len_nz;
    logic fifo_full;
    logic fifo_empty;
    logic req_accept;
    logic push;
    logic pop;

    // Depth is a power of two, so the count MSB alone marks "full".
    assign len_nz     = (line_len_i != 7'd0);
    assign fifo_full  = count[PTR_W];
    assign fifo_empty = (count == '0);
    assign req_accept = wb_strobe_o && !wb_stall_i;
    // A new line_start discards whatever ack lands in the same cycle.
    assign push       = (state == WAIT_ACK) && wb_ack_i && !line_start_i && !wb_reset_i;
    assign pop        = rd_en_i && !fifo_empty;

    assign wb_we_o   = 1'b0;
    assign wb_data_o = '0;
    assign empty_o   = fifo_empty || wb_reset_i;
    assign rd_data_o = empty_o ? '0 : mem[rd_ptr];

    // State register
    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) state <= IDLE;
        else            state <= state_next;
    end

    // Next-state logic; line_start_i overrides everything outside reset
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (line_start_i && len_nz) state_next = REQ;
            end
            REQ: begin
                if (line_start_i)    state_next = len_nz ? REQ : IDLE;
                else if (req_accept) state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (line_start_i)  state_next = len_nz ? ABORT : IDLE;
                else if (wb_ack_i) state_next = (remaining == 7'd1) ? IDLE : REQ;
            end
            ABORT: begin
                state_next = (line_start_i && !len_nz) ? IDLE : REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs; strobe only when a FIFO slot is free, dropped at once on a restart
    always_comb begin
        wb_cycle_o  = 1'b0;
        wb_strobe_o = 1'b0;
        wb_addr_o   = '0;
        busy_o      = 1'b0;
        if (!wb_reset_i) begin
            busy_o = (state != IDLE);
            case (state)
                REQ: begin
                    if (!fifo_full && !line_start_i) begin
                        wb_cycle_o  = 1'b1;
                        wb_strobe_o = 1'b1;
                        wb_addr_o   = VRAM_BASE + {{(WB_ADDR_WIDTH-11){1'b0}}, offset};
                    end
                end
                WAIT_ACK: wb_cycle_o = 1'b1;
                default: ;
            endcase
        end
    end

    // Line offset and remaining byte count; offset wraps modulo 2048
    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            offset    <= 11'd0;
            remaining <= 7'd0;
        end else if (line_start_i) begin
            offset    <= line_addr_i;
            remaining <= line_len_i;
        end else if (push) begin
            offset    <= offset + 11'd1;
            remaining <= remaining - 7'd1;
        end
    end

    // FIFO pointers and count; flush beats a coincident pop
    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i || line_start_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // FIFO storage write
    always_ff @(posedge wb_clock_i) begin
        if (push) mem[wr_ptr] <= wb_data_i;
    end

endmodule
